// File: rtl/burst_mem.sv
// Burst-mode main-memory model: serves one cache line per transaction as
// DRAM_PARAM_BURST_LEN 64-bit beats, with a sticky protocol-error flag.
module burst_mem #(
  parameter int DRAM_PARAM_BURST_LEN = 4,
  parameter int DRAM_PARAM_LATENCY   = 6,
  parameter int MEM_LOG2_WORDS       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        read,
  input  logic        write,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        resp,
  output logic        error
);

  localparam int AW    = MEM_LOG2_WORDS;
  localparam int BW    = $clog2(DRAM_PARAM_BURST_LEN);
  localparam int LW    = (DRAM_PARAM_LATENCY > 1) ? $clog2(DRAM_PARAM_LATENCY) : 1;
  localparam int ALIGN = $clog2(DRAM_PARAM_BURST_LEN * 8);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RLAT   = 3'd1,
    RBURST = 3'd2,
    WBURST = 3'd3,
    WRESP  = 3'd4
  } state_t;

  state_t        state_q;
  logic [31:0]   addr_q;
  logic [AW-1:0] base_q;
  logic [BW-1:0] beat_q;
  logic [LW-1:0] cnt_q;
  logic [63:0]   rdata_q;
  logic          resp_q;
  logic          error_q;

  logic [63:0]   mem_q [2**AW];
  logic          mem_we;
  logic [AW-1:0] mem_widx;

  // Beat 0 of a write is stored in the accepting cycle, straight from addr.
  always_comb begin
    mem_we   = 1'b0;
    mem_widx = base_q + AW'(beat_q);
    if (rst_n) begin
      if (state_q == IDLE && write && !read) begin
        mem_we   = 1'b1;
        mem_widx = addr[AW+2:3];
      end else if (state_q == WBURST) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= wdata;
  end

  // The final read beat and the write response are driven while the FSM is
  // already back in IDLE, so the next request can be accepted on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      base_q  <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      resp_q  <= 1'b0;
      rdata_q <= '0;
      if (read && write) error_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (read ^ write) begin
            addr_q <= addr;
            base_q <= addr[AW+2:3];
            cnt_q  <= '0;
            if (addr[ALIGN-1:0] != '0) error_q <= 1'b1;
            if (read) begin
              beat_q  <= '0;
              state_q <= RLAT;
            end else begin
              beat_q  <= BW'(1);
              state_q <= WBURST;
            end
          end
        end
        RLAT: begin
          if (write || addr != addr_q) error_q <= 1'b1;
          if (cnt_q == LW'(DRAM_PARAM_LATENCY - 1)) begin
            resp_q  <= 1'b1;
            rdata_q <= mem_q[base_q];
            beat_q  <= BW'(1);
            state_q <= RBURST;
          end else begin
            cnt_q <= cnt_q + LW'(1);
          end
        end
        RBURST: begin
          if (write) error_q <= 1'b1;
          resp_q  <= 1'b1;
          rdata_q <= mem_q[base_q + AW'(beat_q)];
          if (beat_q == BW'(DRAM_PARAM_BURST_LEN - 1)) begin
            beat_q  <= '0;
            state_q <= IDLE;
          end else begin
            beat_q <= beat_q + BW'(1);
          end
        end
        WBURST: begin
          if (!write || read || addr != addr_q) error_q <= 1'b1;
          if (beat_q == BW'(DRAM_PARAM_BURST_LEN - 1)) begin
            beat_q  <= '0;
            state_q <= WRESP;
          end else begin
            beat_q <= beat_q + BW'(1);
          end
        end
        WRESP: begin
          if (read) error_q <= 1'b1;
          resp_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata = rdata_q;
  assign resp  = resp_q;
  assign error = error_q;

endmodule

// File: tb/tb_burst_mem.sv
// Directed bench for burst_mem: scoreboard of expected read beats plus
// protocol-violation and reset checks.
module tb_burst_mem;

  localparam int BL  = 4;
  localparam int LAT = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        read;
  logic        write;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        resp;
  logic        error;

  int checks   = 0;
  int failures = 0;
  logic [63:0] sb_q [$];

  burst_mem #(
    .DRAM_PARAM_BURST_LEN(BL),
    .DRAM_PARAM_LATENCY  (LAT),
    .MEM_LOG2_WORDS      (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (addr),
    .read (read),
    .write(write),
    .wdata(wdata),
    .rdata(rdata),
    .resp (resp),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    read  = 1'b0;
    write = 1'b0;
    #1;
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_resp", 64'(resp), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] b0, input logic [63:0] b1,
                          input logic [63:0] b2, input logic [63:0] b3);
    logic [63:0] beats [BL];
    beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
    addr  = a;
    write = 1'b1;
    for (int k = 0; k < BL; k++) begin
      wdata = beats[k];
      tick();
      chk("wr_beat_resp_low", 64'(resp), 64'd0);
    end
    write = 1'b0;
    wdata = '0;
    tick();
    chk("wr_resp", 64'(resp), 64'd1);
    chk("wr_resp_rdata", rdata, 64'd0);
    chk("wr_error", 64'(error), 64'd0);
  endtask

  task automatic do_read(input logic [31:0] a);
    int n;
    logic [63:0] exp;
    addr = a;
    read = 1'b1;
    tick();
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (resp) break;
    end
    chk("rd_latency", 64'(n), 64'(LAT));
    read = 1'b0;
    for (int k = 0; k < BL; k++) begin
      if (k > 0) tick();
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hDEAD;
      chk("rd_resp", 64'(resp), 64'd1);
      chk("rd_data", rdata, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    addr  = '0;
    read  = 1'b0;
    write = 1'b0;
    wdata = '0;

    // Reset then idle.
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_resp", 64'(resp), 64'd0);
      chk("idle_error", 64'(error), 64'd0);
      chk("idle_rdata", rdata, 64'd0);
    end

    // Write/read round trip.
    do_write(32'h100, 64'h1111111111111111, 64'h2222222222222222,
             64'h3333333333333333, 64'h4444444444444444);
    tick();
    sb_q.push_back(64'h1111111111111111);
    sb_q.push_back(64'h2222222222222222);
    sb_q.push_back(64'h3333333333333333);
    sb_q.push_back(64'h4444444444444444);
    do_read(32'h100);
    tick();

    // Unwritten line reads as zero.
    for (int k = 0; k < BL; k++) sb_q.push_back(64'd0);
    do_read(32'h2000);
    chk("unwritten_error", 64'(error), 64'd0);
    tick();

    // Back-to-back write then read with no idle cycle.
    do_write(32'h40, 64'hA0A0A0A0A0A0A0A0, 64'hA1A1A1A1A1A1A1A1,
             64'hA2A2A2A2A2A2A2A2, 64'hA3A3A3A3A3A3A3A3);
    sb_q.push_back(64'hA0A0A0A0A0A0A0A0);
    sb_q.push_back(64'hA1A1A1A1A1A1A1A1);
    sb_q.push_back(64'hA2A2A2A2A2A2A2A2);
    sb_q.push_back(64'hA3A3A3A3A3A3A3A3);
    do_read(32'h40);

    // Write, overwrite, read back.
    do_write(32'h80, 64'h0101010101010101, 64'h0202020202020202,
             64'h0303030303030303, 64'h0404040404040404);
    do_write(32'h80, 64'hB0B0B0B0B0B0B0B0, 64'hB1B1B1B1B1B1B1B1,
             64'hB2B2B2B2B2B2B2B2, 64'hB3B3B3B3B3B3B3B3);
    sb_q.push_back(64'hB0B0B0B0B0B0B0B0);
    sb_q.push_back(64'hB1B1B1B1B1B1B1B1);
    sb_q.push_back(64'hB2B2B2B2B2B2B2B2);
    sb_q.push_back(64'hB3B3B3B3B3B3B3B3);
    do_read(32'h80);
    chk("b2b_error", 64'(error), 64'd0);
    tick();

    // Misaligned read.
    addr = 32'h108;
    read = 1'b1;
    tick();
    chk("misalign_error", 64'(error), 64'd1);
    read = 1'b0;
    tick();
    chk("misalign_held1", 64'(error), 64'd1);
    tick();
    chk("misalign_held2", 64'(error), 64'd1);
    rst_pulse();

    // Read and write together.
    addr  = 32'h100;
    read  = 1'b1;
    write = 1'b1;
    tick();
    chk("rw_error", 64'(error), 64'd1);
    read  = 1'b0;
    write = 1'b0;
    tick();
    chk("rw_no_accept_resp", 64'(resp), 64'd0);
    chk("rw_held", 64'(error), 64'd1);
    rst_pulse();

    // Write dropped after two beats.
    addr  = 32'h300;
    write = 1'b1;
    wdata = 64'h5;
    tick();
    tick();
    chk("wdrop_before", 64'(error), 64'd0);
    write = 1'b0;
    tick();
    chk("wdrop_error", 64'(error), 64'd1);
    tick();
    tick();
    chk("wdrop_held", 64'(error), 64'd1);
    rst_pulse();

    // Mid-read reset during beat 1.
    sb_q.push_back(64'h1111111111111111);
    sb_q.push_back(64'h2222222222222222);
    addr = 32'h100;
    read = 1'b1;
    for (int i = 0; i <= LAT; i++) tick();
    read = 1'b0;
    chk("midrst_beat0_resp", 64'(resp), 64'd1);
    chk("midrst_beat0", rdata, sb_q.pop_front());
    tick();
    chk("midrst_beat1", rdata, sb_q.pop_front());
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_resp_async", 64'(resp), 64'd0);
    chk("midrst_rdata_async", rdata, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    sb_q.push_back(64'h1111111111111111);
    sb_q.push_back(64'h2222222222222222);
    sb_q.push_back(64'h3333333333333333);
    sb_q.push_back(64'h4444444444444444);
    do_read(32'h100);
    chk("post_rst_error", 64'(error), 64'd0);
    tick();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
